weight_loader_pipelined: RTL and testbench
==========================================

Name: weight_loader_pipelined

Overview:
- Parametrised successor to the per-layer weight loaders.
- One instance serves any layer: base address is a run-time input captured on start; BRAM read latency is a parameter.
- The BRAM sits outside the block; the loader drives its read port and packs TOTAL_WEIGHTS words into a flat bus for the MAC array.
- Adds reset, a busy flag and restart-after-done. Also handles the in-flight pipeline depth for any latency.

Parameters:
- IN_SIZE, 256, inputs per neuron
- OUT_SIZE, 8, neurons in layer
- W, 8, weight word width in bits
- TOTAL_WEIGHTS, IN_SIZE*OUT_SIZE, words loaded per run (derived, never overridden)
- ADDR_WIDTH, 15, BRAM address width
- RD_LATENCY, 2, BRAM cycles from address to data; legal range 1..4

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE
- base_addr  in  ADDR_WIDTH  first BRAM address; sampled on the cycle start is accepted
- bram_en  out  1  BRAM enable / read strobe
- bram_addr  out  ADDR_WIDTH  BRAM read address
- bram_dout  in  W  BRAM read data
- data_out  out  TOTAL_WEIGHTS*W  packed weights; word i sits at [i*W +: W]
- busy  out  1  high in READ and DRAIN
- done  out  1  level; high in DONE until the next accepted start

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; bram_en=0; bram_addr=0; data_out=0; busy=0; done=0.
  - Issue counter, capture pointer and valid pipe are all cleared.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE/DONE -> READ on start=1:
  - Capture base_addr.
  - Clear the pointers. done falls on the next cycle.
  - data_out is not cleared; slots are overwritten as they arrive.
- READ:
  - bram_en=1. bram_addr = base+n in cycle n, for n=0..TOTAL_WEIGHTS-1.
  - The cycle after the last address is issued: bram_en=0, state -> DRAIN.
- Valid pipe:
  - RD_LATENCY-deep shift register; 1 is shifted in each cycle an address is issued.
  - When the pipe tail is 1: data_out[wr_ptr] <= bram_dout and wr_ptr++.
  - Design rule: no fixed "skip first two" counts.
- DRAIN -> DONE when wr_ptr==TOTAL_WEIGHTS.
- Timing:
  - start is accepted at edge E0. The first address is presented in the cycle after E0.
  - The last word is captured at edge E0+TOTAL_WEIGHTS+RD_LATENCY.
  - done rises in the cycle after that edge.
- start while busy: ignored, with no effect on pointers or outputs.
- Address wrap: base_addr+n is taken modulo 2^ADDR_WIDTH.
- Counter widths: $clog2(TOTAL_WEIGHTS+1).
- Reset during READ or DRAIN:
  - Immediate return to IDLE with data_out=0.
  - In-flight BRAM data is discarded.
- All outputs are registered.

Optional Feature:
- Macro: WL_STREAM_EN.
- Defined adds three ports:
  - stream_valid out 1, pulses on each capture.
  - stream_data out W, the captured word.
  - stream_idx out $clog2(TOTAL_WEIGHTS), equal to wr_ptr at capture.
  - These mirror each capture in the same cycle data_out updates.
  - All three reset to 0.
- Undefined: these ports and their logic are absent. data_out behaviour is identical either way.

Test Plan:
- Basic load:
  - Setup: IN_SIZE=4, OUT_SIZE=2, RD_LATENCY=2; BRAM model returns mem[a]=a[7:0]; base_addr=6144.
  - Required: every word i of data_out equals (6144+i)&8'hFF. done rises exactly 11 cycles after the start edge. busy is high for 10 cycles.
- Latency sweep:
  - Setup: repeat the basic load with RD_LATENCY=1, 3 and 4.
  - Required: data_out is identical each time. done arrives at TOTAL_WEIGHTS+RD_LATENCY+1 cycles.
- Wrap and reload:
  - Setup: base_addr=32766 with 8 words, then start again with base=100 while in DONE.
  - Required: first run words 0..1 = 0xFE,0xFF and words 2..7 = 0x00..0x05. Second run all words = 100+i. done is low for the duration of the second run.
- Busy start:
  - Setup: pulse start with base=0 while in READ at cycle 3.
  - Required: no restart; the addresses continue from the original base; the final data matches the first run.
- Mid-run reset:
  - Setup: assert rst_n=0 asynchronously in cycle 5 of READ, then release and start with base=200.
  - Required: data_out=0, done=0 and bram_en=0 immediately. The subsequent run produces words 200+i.
- Stream (WL_STREAM_EN):
  - Required: exactly TOTAL_WEIGHTS stream_valid pulses, with stream_idx running 0..7 and stream_data matching data_out slots.

Source files
------------

// File: rtl/weight_loader_pipelined.sv
// Weight loader: streams TOTAL_WEIGHTS BRAM words into a flat bus, any read latency.
// Optional capture stream ports under `WL_STREAM_EN.
module weight_loader_pipelined #(
  parameter int IN_SIZE    = 256,
  parameter int OUT_SIZE   = 8,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int RD_LATENCY = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  output logic                           bram_en,
  output logic [ADDR_WIDTH-1:0]          bram_addr,
  input  logic [W-1:0]                   bram_dout,
  output logic [IN_SIZE*OUT_SIZE*W-1:0]  data_out,
`ifdef WL_STREAM_EN
  output logic                           stream_valid,
  output logic [W-1:0]                   stream_data,
  output logic [((IN_SIZE*OUT_SIZE) > 1 ? $clog2(IN_SIZE*OUT_SIZE) : 1)-1:0] stream_idx,
`endif
  output logic                           busy,
  output logic                           done
);

  localparam int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE;
  localparam int CW = $clog2(TOTAL_WEIGHTS + 1);
  localparam int IW = (TOTAL_WEIGHTS > 1) ? $clog2(TOTAL_WEIGHTS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TOTAL_WEIGHTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic                         en_q, en_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [CW-1:0]                iss_q, iss_d;
  logic [CW-1:0]                wr_q, wr_d;
  logic [RD_LATENCY-1:0]        pipe_q, pipe_d;
  logic [TOTAL_WEIGHTS*W-1:0]   data_q, data_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         cap;

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    addr_d  = addr_q;
    iss_d   = iss_q;
    wr_d    = wr_q;
    data_d  = data_q;
    // tail of the valid pipe marks the cycle bram_dout holds a requested word
    pipe_d  = (pipe_q << 1) | RD_LATENCY'(en_q);
    cap     = pipe_q[RD_LATENCY-1];
    busy_d  = (state_q == S_READ) || (state_q == S_DRAIN);
    done_d  = (state_q == S_DONE);

    if (cap) begin
      for (int i = 0; i < TOTAL_WEIGHTS; i++) begin
        if (wr_q == CW'(i)) data_d[i*W +: W] = bram_dout;
      end
      wr_d = wr_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_READ;
          en_d    = 1'b1;
          addr_d  = base_addr;
          iss_d   = CW'(1);
          wr_d    = '0;
          pipe_d  = '0;
        end
      end
      S_READ: begin
        if (iss_q == LAST) begin
          en_d    = 1'b0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
          iss_d  = iss_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (wr_d == LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      addr_q  <= '0;
      iss_q   <= '0;
      wr_q    <= '0;
      pipe_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      iss_q   <= iss_d;
      wr_q    <= wr_d;
      pipe_q  <= pipe_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bram_en   = en_q;
  assign bram_addr = addr_q;
  assign data_out  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef WL_STREAM_EN
  logic          sv_q;
  logic [W-1:0]  sd_q;
  logic [IW-1:0] si_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q <= 1'b0;
      sd_q <= '0;
      si_q <= '0;
    end else begin
      sv_q <= cap;
      if (cap) begin
        sd_q <= bram_dout;
        si_q <= wr_q[IW-1:0];
      end
    end
  end

  assign stream_valid = sv_q;
  assign stream_data  = sd_q;
  assign stream_idx   = si_q;
`endif

endmodule

// File: tb/tb_weight_loader_pipelined.sv
// Bench: four loaders (read latency 1..4) run side by side against
// per-instance BRAM delay models and a plain-arithmetic reference.
module tb_weight_loader_pipelined;

  localparam int IN = 4;
  localparam int OUT = 2;
  localparam int W = 8;
  localparam int T = IN * OUT;
  localparam int AW = 15;
  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;

  logic          en   [ND];
  logic [AW-1:0] addr [ND];
  logic [W-1:0]  dout [ND];
  logic [T*W-1:0] dat [ND];
  logic          busy [ND];
  logic          done [ND];
`ifdef WL_STREAM_EN
  logic          sv [ND];
  logic [W-1:0]  sd [ND];
  logic [2:0]    si [ND];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic [W-1:0] dl [g+1];
    always @(posedge clk) begin
      dl[0] <= en[g] ? addr[g][7:0] : 8'($urandom);
      for (int i = 1; i <= g; i++) dl[i] <= dl[i-1];
    end
    assign dout[g] = dl[g];

    weight_loader_pipelined #(
      .IN_SIZE(IN), .OUT_SIZE(OUT), .W(W),
      .ADDR_WIDTH(AW), .RD_LATENCY(g + 1)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .base_addr(base),
      .bram_en(en[g]),
      .bram_addr(addr[g]),
      .bram_dout(dout[g]),
      .data_out(dat[g]),
`ifdef WL_STREAM_EN
      .stream_valid(sv[g]),
      .stream_data(sd[g]),
      .stream_idx(si[g]),
`endif
      .busy(busy[g]),
      .done(done[g])
    );
  end

  function automatic logic [W-1:0] expw(logic [AW-1:0] b, int i);
    logic [AW-1:0] a;
    a = AW'(int'(b) + i);
    return a[7:0];
  endfunction

  function automatic logic [T*W-1:0] expv(logic [AW-1:0] b);
    logic [T*W-1:0] v;
    for (int i = 0; i < T; i++) v[i*W +: W] = expw(b, i);
    return v;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(logic [AW-1:0] b, bit poke);
    int dc [ND];
    int bc [ND];
    int sc [ND];
    for (int k = 0; k < ND; k++) begin
      dc[k] = 0; bc[k] = 0; sc[k] = 0;
    end
    @(negedge clk);
    base  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base  = AW'($urandom);
    for (int c = 1; c <= T + 10; c++) begin
      @(posedge clk);
      #1;
      if (poke && c == 3) begin
        base  = '0;
        start = 1'b1;
      end
      if (poke && c == 4) start = 1'b0;
      for (int k = 0; k < ND; k++) begin
        if (c == 1) chk($sformatf("done_fall_L%0d", k + 1), 64'(done[k]), 64'd0);
        if (busy[k]) bc[k]++;
        if (done[k] && dc[k] == 0) dc[k] = c;
`ifdef WL_STREAM_EN
        if (sv[k]) begin
          chk($sformatf("s_idx_L%0d", k + 1), 64'(si[k]), 64'(sc[k] % T));
          chk($sformatf("s_dat_L%0d", k + 1), 64'(sd[k]), 64'(expw(b, sc[k])));
          sc[k]++;
        end
`endif
      end
    end
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("done_at_L%0d", k + 1), 64'(dc[k]), 64'(T + k + 2));
      chk($sformatf("busy_len_L%0d", k + 1), 64'(bc[k]), 64'(T + k + 1));
      chk($sformatf("data_L%0d_b%0d", k + 1, b), 64'(dat[k]), 64'(expv(b)));
      chk($sformatf("done_hold_L%0d", k + 1), 64'(done[k]), 64'd1);
`ifdef WL_STREAM_EN
      chk($sformatf("s_cnt_L%0d", k + 1), 64'(sc[k]), 64'(T));
`endif
    end
  endtask

  initial begin
    #12;
    for (int k = 0; k < ND; k++) begin
      chk("rst_data", 64'(dat[k]), 64'd0);
      chk("rst_ctl", {60'd0, en[k], busy[k], done[k], 1'b0}, 64'd0);
      chk("rst_addr", 64'(addr[k]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run(15'd6144, 1'b0);
    run(15'd1000, 1'b1);
    run(15'd32766, 1'b0);
    chk("wrap_lo", 64'(dat[1][15:0]), 64'h0000_0000_0000_fffe);
    chk("wrap_hi", 64'(dat[1][63:16]), 64'h0000_0504_0302_0100);
    run(15'd100, 1'b0);
    for (int r = 0; r < 3; r++) run(AW'($urandom), 1'b0);

    @(negedge clk);
    base  = 15'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      chk("mid_rst_data", 64'(dat[k]), 64'd0);
      chk("mid_rst_ctl", {61'd0, en[k], busy[k], done[k]}, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(15'd200, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
